fp_flag_monitor: RTL
====================

Name: fp_flag_monitor

Overview:
- Parametrised, pipelined runtime checker for IEEE-754 binary FP operation streams, for any exponent/fraction width.
- Receives one transaction per handshake: operands, rounding mode, op code, result and exception flags from the FP unit under test.
- Classifies operands and result, then evaluates the generic edge-case rules for NaN propagation, flag/result consistency and rounding-mode overflow values.
- Reports a per-transaction violation mask on a backpressured stream and keeps sticky accrued flags, a saturating violation counter and a first-violation capture. Sits beside an FP core in simulation and formal harnesses.

Parameters:
EXP_W, 8, exponent field width
FRAC_W, 23, stored fraction width; W = 1+EXP_W+FRAC_W
CNT_W, 16, violation counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  transaction valid
in_ready  out  1  transaction accepted when in_valid && in_ready
a, b, c  in  W each  operands; c is used only when op=FMA
rm  in  5  one-hot rounding mode: bit0 RNE, bit1 RNA, bit2 RTP, bit3 RTN, bit4 RTZ
op  in  2  operation: 00 ADD, 01 MUL, 10 DIV, 11 FMA
o  in  W  result under test
flags  in  5  {NV,DZ,OF,UF,NX}
rpt_valid  out  1  report valid
rpt_ready  in  1  report consumed
rpt_viol  out  10  violation mask for the reported transaction
rpt_flags  out  5  flags of the reported transaction
acc_clr  in  1  clears sticky state
acc_flags  out  5  OR of the flags of all reported transactions since the last clear
viol_cnt  out  CNT_W  saturating count of reports with a nonzero mask
first_valid  out  1  first-violation capture holds data
first_viol  out  10  mask of the first violating report
first_o  out  W  result value of the first violating report

Behaviour:
- Classes, per value:
  - zero: exp=0, frac=0
  - subnormal: exp=0, frac≠0
  - normal: all other finite values
  - inf: exp=all-ones, frac=0
  - NaN: exp=all-ones, frac≠0; qNaN has frac MSB=1, sNaN has frac MSB=0
  - ebmin: exp=1, frac=0
- Pipeline:
  - S1 registers the classifications, rm, op, o and flags.
  - S2 registers the violation mask.
  - Report comes from S2, so latency is 2 cycles with full throughput.
- Handshake:
  - adv2 = !s2_v || rpt_ready; adv1 = !s1_v || adv2; in_ready = adv1.
  - rpt_valid = s2_v. Report data is stable while rpt_valid && !rpt_ready.
  - No drop, no duplication, order preserved.
- Check bits (the set bit means a violation):
  - 0 NANPROP: an input NaN (a, b, or c when FMA) and (!o NaN or any of DZ/OF/UF/NX set).
  - 1 SNAN: an input sNaN and !NV.
  - 2 DZINF: DZ and !o inf.
  - 3 NVQNAN: NV and !o qNaN.
  - 4 INEXACT: (OF or UF) and !NX.
  - 5 UFRANGE: UF and o is not subnormal, zero or ebmin.
  - 6 OFVAL: OF and the result is wrong for rm:
    - RNE/RNA require inf.
    - RTP requires +inf or -max.
    - RTN requires +max or -inf.
    - RTZ requires ±max.
  - 7 EXACT: (o inf and !OF and NX) or (o subnormal and !UF and NX).
  - 8 DZLEGAL: for DIV, DZ ≠ (a finite-nonzero and b zero); for other ops, DZ set.
  - 9 BADRM: rm is not one-hot. While set, bit 6 is forced to 0.
- Sticky state updates on the report handshake only:
  - acc_flags |= rpt_flags.
  - If the mask is nonzero, viol_cnt increments, saturating at all-ones.
  - If the mask is nonzero and !first_valid, load first_viol and first_o and set first_valid.
- acc_clr:
  - Zeroes acc_flags, viol_cnt and first_valid, first_viol, first_o.
  - If a handshake happens in the same cycle, the state afterwards reflects only that handshake: clear first, then update.
  - acc_clr does not affect pipeline contents.
- Reset:
  - Asynchronous. All registers and outputs go to 0 immediately (in_ready=0 while rst_n=0). In-flight transactions are discarded.
  - in_ready=1 on the first clock after deassertion.

Decomposition:
- Package fp_flag_pkg:
  - Flag bit indices (NV=4, DZ=3, OF=2, UF=1, NX=0)
  - Check index constants 0..9 and NCHK=10
  - rm one-hot constants
  - op encodings
  - Class struct typedef
- Sub-module fp_classify (combinational, parameters EXP_W/FRAC_W) produces the class struct. It is instantiated four times (a, b, c, o).

Test Plan:
- 32-bit build. a=7fc00000, b=3f800000, op ADD, o=7fc00000, flags 0 → two cycles after acceptance: rpt_valid=1, rpt_viol=0, acc_flags=0.
- a=7f800001 (sNaN), o=7fc00000, flags 0 → rpt_viol[1]=1, viol_cnt=1, first_valid=1, first_o=7fc00000.
- op DIV, a=3f800000, b=00000000, o=7f800000, flags=01000 → rpt_viol=0, acc_flags=01000. Same inputs with op ADD → rpt_viol[8]=1.
- rm=10000, o=7f800000, flags=00101 → rpt_viol[6]=1. rm=00011 → rpt_viol[9]=1 and rpt_viol[6]=0.
- rpt_ready=0 for 5 cycles while in_valid=1 → exactly 2 accepted then in_ready=0; after release, reports come out in order with no loss or duplicate.
- CNT_W=2 with 5 violating reports → viol_cnt=3. acc_clr in the same cycle as a report with flags=00001 → acc_flags=00001. rst_n low mid-stream → all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/fp_flag_monitor_pkg.sv
// fp_flag_pkg: shared flag/check indices, encodings and the FP value class record.
// Revision: 1.0
`default_nettype none

package fp_flag_pkg;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam int CHK_NANPROP = 0;
  localparam int CHK_SNAN    = 1;
  localparam int CHK_DZINF   = 2;
  localparam int CHK_NVQNAN  = 3;
  localparam int CHK_INEXACT = 4;
  localparam int CHK_UFRANGE = 5;
  localparam int CHK_OFVAL   = 6;
  localparam int CHK_EXACT   = 7;
  localparam int CHK_DZLEGAL = 8;
  localparam int CHK_BADRM   = 9;
  localparam int NCHK        = 10;

  localparam logic [4:0] RM_RNE = 5'b00001;
  localparam logic [4:0] RM_RNA = 5'b00010;
  localparam logic [4:0] RM_RTP = 5'b00100;
  localparam logic [4:0] RM_RTN = 5'b01000;
  localparam logic [4:0] RM_RTZ = 5'b10000;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_DIV = 2'b10,
    OP_FMA = 2'b11
  } op_e;

  typedef struct packed {
    logic sign;
    logic zero;
    logic sub;
    logic norm;
    logic inf;
    logic nan;
    logic qnan;
    logic snan;
    logic ebmin;
    logic maxf;
  } fp_class_t;

  function automatic logic rm_is_onehot(input logic [4:0] rm);
    return (rm != 5'd0) && ((rm & (rm - 5'd1)) == 5'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_flag_monitor_if.sv
// fp_flag_monitor_if: transaction, report and sticky-state signals of the flag monitor.
// Revision: 1.0
`default_nettype none

interface fp_flag_monitor_if #(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23,
  parameter int CNT_W = 16
);
  import fp_flag_pkg::*;

  localparam int W = 1 + EXP_W + FRAC_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [W-1:0]     c;
  logic [4:0]       rm;
  logic [1:0]       op;
  logic [W-1:0]     o;
  logic [4:0]       flags;

  logic             rpt_valid;
  logic             rpt_ready;
  logic [NCHK-1:0]  rpt_viol;
  logic [4:0]       rpt_flags;

  logic             acc_clr;
  logic [4:0]       acc_flags;
  logic [CNT_W-1:0] viol_cnt;
  logic             first_valid;
  logic [NCHK-1:0]  first_viol;
  logic [W-1:0]     first_o;

  modport master (
    output in_valid, a, b, c, rm, op, o, flags, rpt_ready, acc_clr,
    input  in_ready, rpt_valid, rpt_viol, rpt_flags,
    input  acc_flags, viol_cnt, first_valid, first_viol, first_o
  );

  modport slave (
    input  in_valid, a, b, c, rm, op, o, flags, rpt_ready, acc_clr,
    output in_ready, rpt_valid, rpt_viol, rpt_flags,
    output acc_flags, viol_cnt, first_valid, first_viol, first_o
  );

endinterface

`default_nettype wire

// File: rtl/fp_flag_monitor_classify.sv
// fp_classify: combinational IEEE-754 class decode of one value.
// Revision: 1.0
`default_nettype none

module fp_classify
  import fp_flag_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23
) (
  input  logic [EXP_W+FRAC_W:0] i_val,
  output fp_class_t             o_cls
);

  logic [EXP_W-1:0]  w_exp;
  logic [FRAC_W-1:0] w_frac;
  logic              w_exp_ones;
  logic              w_exp_zero;
  logic              w_frac_zero;

  assign w_exp       = i_val[EXP_W+FRAC_W-1:FRAC_W];
  assign w_frac      = i_val[FRAC_W-1:0];
  assign w_exp_ones  = &w_exp;
  assign w_exp_zero  = ~|w_exp;
  assign w_frac_zero = ~|w_frac;

  always_comb begin
    o_cls       = '0;
    o_cls.sign  = i_val[EXP_W+FRAC_W];
    o_cls.zero  = w_exp_zero & w_frac_zero;
    o_cls.sub   = w_exp_zero & ~w_frac_zero;
    o_cls.norm  = ~w_exp_zero & ~w_exp_ones;
    o_cls.inf   = w_exp_ones & w_frac_zero;
    o_cls.nan   = w_exp_ones & ~w_frac_zero;
    o_cls.qnan  = w_exp_ones & w_frac[FRAC_W-1];
    o_cls.snan  = w_exp_ones & ~w_frac_zero & ~w_frac[FRAC_W-1];
    o_cls.ebmin = (w_exp == EXP_W'(1)) & w_frac_zero;
    // largest finite magnitude: exponent all-ones-minus-one, fraction all ones
    o_cls.maxf  = (w_exp == {{(EXP_W-1){1'b1}}, 1'b0}) & (&w_frac);
  end

endmodule

`default_nettype wire

// File: rtl/fp_flag_monitor.sv
// fp_flag_monitor: two-stage pipelined IEEE-754 flag/result consistency checker with sticky state.
// Revision: 1.0
`default_nettype none

module fp_flag_monitor
  import fp_flag_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_flag_monitor_if.slave bus
);

  localparam int W = 1 + EXP_W + FRAC_W;

  fp_class_t w_cls_a, w_cls_b, w_cls_c, w_cls_o;

  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_a (.i_val(bus.a), .o_cls(w_cls_a));
  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_b (.i_val(bus.b), .o_cls(w_cls_b));
  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_c (.i_val(bus.c), .o_cls(w_cls_c));
  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_o (.i_val(bus.o), .o_cls(w_cls_o));

  logic             r_s1_v;
  fp_class_t        r_s1_ca, r_s1_cb, r_s1_cc, r_s1_co;
  logic [4:0]       r_s1_rm;
  op_e              r_s1_op;
  logic [W-1:0]     r_s1_o;
  logic [4:0]       r_s1_flags;

  logic             r_s2_v;
  logic [NCHK-1:0]  r_s2_viol;
  logic [4:0]       r_s2_flags;
  logic [W-1:0]     r_s2_o;

  logic             w_adv1, w_adv2, w_accept, w_rpt_hs;
  logic [NCHK-1:0]  w_viol;

  assign w_adv2   = ~r_s2_v | bus.rpt_ready;
  assign w_adv1   = ~r_s1_v | w_adv2;
  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_rpt_hs = r_s2_v & bus.rpt_ready;

  // ready is forced low for the whole time reset is asserted
  assign bus.in_ready = rst_n & w_adv1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v     <= 1'b0;
      r_s1_ca    <= '0;
      r_s1_cb    <= '0;
      r_s1_cc    <= '0;
      r_s1_co    <= '0;
      r_s1_rm    <= '0;
      r_s1_op    <= OP_ADD;
      r_s1_o     <= '0;
      r_s1_flags <= '0;
    end else if (w_adv1) begin
      r_s1_v <= w_accept;
      if (w_accept) begin
        r_s1_ca    <= w_cls_a;
        r_s1_cb    <= w_cls_b;
        r_s1_cc    <= w_cls_c;
        r_s1_co    <= w_cls_o;
        r_s1_rm    <= bus.rm;
        r_s1_op    <= op_e'(bus.op);
        r_s1_o     <= bus.o;
        r_s1_flags <= bus.flags;
      end
    end
  end

  logic w_in_nan, w_in_snan, w_badrm, w_of_ok, w_dz_expect;

  always_comb begin
    w_viol      = '0;
    w_in_nan    = r_s1_ca.nan  | r_s1_cb.nan  | ((r_s1_op == OP_FMA) & r_s1_cc.nan);
    w_in_snan   = r_s1_ca.snan | r_s1_cb.snan | ((r_s1_op == OP_FMA) & r_s1_cc.snan);
    w_badrm     = ~rm_is_onehot(r_s1_rm);
    w_dz_expect = (r_s1_op == OP_DIV) & (r_s1_ca.sub | r_s1_ca.norm) & r_s1_cb.zero;

    if (r_s1_rm[0] | r_s1_rm[1]) begin
      w_of_ok = r_s1_co.inf;
    end else if (r_s1_rm[2]) begin
      w_of_ok = (r_s1_co.inf & ~r_s1_co.sign) | (r_s1_co.maxf & r_s1_co.sign);
    end else if (r_s1_rm[3]) begin
      w_of_ok = (r_s1_co.maxf & ~r_s1_co.sign) | (r_s1_co.inf & r_s1_co.sign);
    end else begin
      w_of_ok = r_s1_co.maxf;
    end

    w_viol[CHK_NANPROP] = w_in_nan & (~r_s1_co.nan | (|r_s1_flags[FLG_DZ:FLG_NX]));
    w_viol[CHK_SNAN]    = w_in_snan & ~r_s1_flags[FLG_NV];
    w_viol[CHK_DZINF]   = r_s1_flags[FLG_DZ] & ~r_s1_co.inf;
    w_viol[CHK_NVQNAN]  = r_s1_flags[FLG_NV] & ~r_s1_co.qnan;
    w_viol[CHK_INEXACT] = (r_s1_flags[FLG_OF] | r_s1_flags[FLG_UF]) & ~r_s1_flags[FLG_NX];
    w_viol[CHK_UFRANGE] = r_s1_flags[FLG_UF] & ~(r_s1_co.sub | r_s1_co.zero | r_s1_co.ebmin);
    w_viol[CHK_OFVAL]   = r_s1_flags[FLG_OF] & ~w_of_ok & ~w_badrm;
    w_viol[CHK_EXACT]   = r_s1_flags[FLG_NX] &
                          ((r_s1_co.inf & ~r_s1_flags[FLG_OF]) | (r_s1_co.sub & ~r_s1_flags[FLG_UF]));
    w_viol[CHK_DZLEGAL] = r_s1_flags[FLG_DZ] ^ w_dz_expect;
    w_viol[CHK_BADRM]   = w_badrm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v     <= 1'b0;
      r_s2_viol  <= '0;
      r_s2_flags <= '0;
      r_s2_o     <= '0;
    end else if (w_adv2) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_viol  <= w_viol;
        r_s2_flags <= r_s1_flags;
        r_s2_o     <= r_s1_o;
      end
    end
  end

  assign bus.rpt_valid = r_s2_v;
  assign bus.rpt_viol  = r_s2_viol;
  assign bus.rpt_flags = r_s2_flags;

  logic [4:0]       r_acc_flags, w_acc_flags_n;
  logic [CNT_W-1:0] r_viol_cnt,  w_viol_cnt_n;
  logic             r_first_v,   w_first_v_n;
  logic [NCHK-1:0]  r_first_viol, w_first_viol_n;
  logic [W-1:0]     r_first_o,   w_first_o_n;

  // clear is applied first so a same-cycle report lands on a clean slate
  always_comb begin
    w_acc_flags_n  = bus.acc_clr ? '0 : r_acc_flags;
    w_viol_cnt_n   = bus.acc_clr ? '0 : r_viol_cnt;
    w_first_v_n    = bus.acc_clr ? 1'b0 : r_first_v;
    w_first_viol_n = bus.acc_clr ? '0 : r_first_viol;
    w_first_o_n    = bus.acc_clr ? '0 : r_first_o;
    if (w_rpt_hs) begin
      w_acc_flags_n = w_acc_flags_n | r_s2_flags;
      if (|r_s2_viol) begin
        if (w_viol_cnt_n != {CNT_W{1'b1}}) begin
          w_viol_cnt_n = w_viol_cnt_n + CNT_W'(1);
        end
        if (!w_first_v_n) begin
          w_first_v_n    = 1'b1;
          w_first_viol_n = r_s2_viol;
          w_first_o_n    = r_s2_o;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_flags  <= '0;
      r_viol_cnt   <= '0;
      r_first_v    <= 1'b0;
      r_first_viol <= '0;
      r_first_o    <= '0;
    end else begin
      r_acc_flags  <= w_acc_flags_n;
      r_viol_cnt   <= w_viol_cnt_n;
      r_first_v    <= w_first_v_n;
      r_first_viol <= w_first_viol_n;
      r_first_o    <= w_first_o_n;
    end
  end

  assign bus.acc_flags   = r_acc_flags;
  assign bus.viol_cnt    = r_viol_cnt;
  assign bus.first_valid = r_first_v;
  assign bus.first_viol  = r_first_viol;
  assign bus.first_o     = r_first_o;

  // class fields that no check consumes for a given operand
  logic w_unused;
  assign w_unused = ^{r_s1_ca, r_s1_cb, r_s1_cc, r_s1_co};

endmodule

`default_nettype wire
